// File: rtl/decode_stage.sv
// PikaRISC decode stage: registered, handshaked field/flag decode with
// load-use bubble insertion, flush support and a saturating stall counter.
module decode_stage #(
   parameter int PC_W         = 32,
   parameter bit HAZARD_EN    = 1'b1,
   parameter bit SIGN_EXT_IMM = 1'b1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic [PC_W-1:0]  pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [5:0]       opcode,
   output logic [3:0]       rd,
   output logic [3:0]       cond,
   output logic [3:0]       rs,
   output logic [3:0]       rt,
   output logic [31:0]      imm_ext,
   output logic [21:0]      md,
   output logic             is_alu_op,
   output logic             is_not_op,
   output logic             is_cmp_op,
   output logic             is_jmp_op,
   output logic             is_ld_op,
   output logic             is_str_op,
   output logic             is_call_op,
   output logic             is_ret_op,
   output logic             is_src2_imm,
   output logic             hazard,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [4:0] OP_NOT  = 5'b00111;
   localparam logic [4:0] OP_JMP  = 5'b10001;
   localparam logic [5:0] OP_CMP  = 6'b100000;
   localparam logic [5:0] OP_LD   = 6'b100100;
   localparam logic [5:0] OP_STR  = 6'b100110;
   localparam logic [5:0] OP_CALL = 6'b101000;
   localparam logic [5:0] OP_RET  = 6'b101010;

   logic [5:0]  w_op;
   logic [3:0]  w_rd, w_rs, w_rt;
   logic [17:0] w_imm;
   logic [31:0] w_imm_ext;
   logic [8:0]  w_flags;
   logic        w_alu, w_not, w_cmp, w_ld, w_str, w_src2;
   logic        w_uses_rs, w_uses_rt, w_uses_rd_src;
   logic        w_hazard, w_in_ready, w_accept;

   logic              r_valid;
   logic [PC_W-1:0]   r_pc;
   logic [31:0]       r_instr;
   logic [31:0]       r_imm_ext;
   logic [8:0]        r_flags;
   logic [CNT_W-1:0]  r_stall_cnt;

   assign w_op  = instruction[31:26];
   assign w_rd  = instruction[25:22];
   assign w_rs  = instruction[21:18];
   assign w_rt  = instruction[17:14];
   assign w_imm = instruction[17:0];

   assign w_alu  = ~instruction[31];
   assign w_not  = (instruction[31:27] == OP_NOT);
   assign w_cmp  = (w_op == OP_CMP);
   assign w_ld   = (w_op == OP_LD);
   assign w_str  = (w_op == OP_STR);
   assign w_src2 = instruction[26];

   // Flag vector order: alu, not, cmp, jmp, ld, str, call, ret, src2_imm
   assign w_flags = {w_alu, w_not, w_cmp, (instruction[31:27] == OP_JMP), w_ld, w_str,
                     (w_op == OP_CALL), (w_op == OP_RET), w_src2};

   generate
      if (SIGN_EXT_IMM) begin : g_sext
         assign w_imm_ext = {{14{w_imm[17]}}, w_imm};
      end else begin : g_zext
         assign w_imm_ext = {14'b0, w_imm};
      end
   endgenerate

   assign w_uses_rs     = w_alu | w_cmp | w_ld | w_str;
   assign w_uses_rt     = ((w_alu & ~w_not) | w_cmp) & ~w_src2;
   assign w_uses_rd_src = w_str;

   // Compare the incoming source registers against the destination of a held load
   assign w_hazard = HAZARD_EN & ~rst & in_valid & r_valid & r_flags[4] &
                     ((w_uses_rs & (w_rs == r_instr[25:22])) |
                      (w_uses_rt & (w_rt == r_instr[25:22])) |
                      (w_uses_rd_src & (w_rd == r_instr[25:22])));

   assign w_in_ready = ~rst & ~flush & ~w_hazard & (~r_valid | out_ready);
   assign w_accept   = in_valid & w_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_instr   <= '0;
         r_imm_ext <= '0;
         r_flags   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_pc      <= pc;
         r_instr   <= instruction;
         r_imm_ext <= w_imm_ext;
         r_flags   <= w_flags;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign in_ready    = w_in_ready;
   assign hazard      = w_hazard;
   assign out_valid   = r_valid;
   assign out_pc      = r_pc;
   assign opcode      = r_instr[31:26];
   assign rd          = r_instr[25:22];
   assign cond        = r_instr[25:22];
   assign rs          = r_instr[21:18];
   assign rt          = r_instr[17:14];
   assign md          = r_instr[21:0];
   assign imm_ext     = r_imm_ext;
   assign is_alu_op   = r_flags[8];
   assign is_not_op   = r_flags[7];
   assign is_cmp_op   = r_flags[6];
   assign is_jmp_op   = r_flags[5];
   assign is_ld_op    = r_flags[4];
   assign is_str_op   = r_flags[3];
   assign is_call_op  = r_flags[2];
   assign is_ret_op   = r_flags[1];
   assign is_src2_imm = r_flags[0];
   assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table-driven decode stream plus hand-written
// hazard, backpressure, flush, saturation and reset sequences.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] instruction, pc;

   logic        a_in_ready, a_out_valid, a_hazard;
   logic [31:0] a_out_pc, a_imm_ext;
   logic [5:0]  a_opcode;
   logic [3:0]  a_rd, a_cond, a_rs, a_rt;
   logic [21:0] a_md;
   logic [8:0]  a_flags;
   logic [15:0] a_stall;

   logic        b_in_ready, b_out_valid, b_hazard;
   logic [31:0] b_out_pc, b_imm_ext;
   logic [5:0]  b_opcode;
   logic [3:0]  b_rd, b_cond, b_rs, b_rt;
   logic [21:0] b_md;
   logic [8:0]  b_flags;
   logic [15:0] b_stall;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decode_stage #(.PC_W(32), .HAZARD_EN(1'b1), .SIGN_EXT_IMM(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .instruction(instruction), .pc(pc), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_out_pc), .opcode(a_opcode), .rd(a_rd), .cond(a_cond), .rs(a_rs), .rt(a_rt),
      .imm_ext(a_imm_ext), .md(a_md),
      .is_alu_op(a_flags[8]), .is_not_op(a_flags[7]), .is_cmp_op(a_flags[6]),
      .is_jmp_op(a_flags[5]), .is_ld_op(a_flags[4]), .is_str_op(a_flags[3]),
      .is_call_op(a_flags[2]), .is_ret_op(a_flags[1]), .is_src2_imm(a_flags[0]),
      .hazard(a_hazard), .stall_count(a_stall));

   decode_stage #(.PC_W(32), .HAZARD_EN(1'b0), .SIGN_EXT_IMM(1'b0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .instruction(instruction), .pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_out_pc), .opcode(b_opcode), .rd(b_rd), .cond(b_cond), .rs(b_rs), .rt(b_rt),
      .imm_ext(b_imm_ext), .md(b_md),
      .is_alu_op(b_flags[8]), .is_not_op(b_flags[7]), .is_cmp_op(b_flags[6]),
      .is_jmp_op(b_flags[5]), .is_ld_op(b_flags[4]), .is_str_op(b_flags[3]),
      .is_call_op(b_flags[2]), .is_ret_op(b_flags[1]), .is_src2_imm(b_flags[0]),
      .hazard(b_hazard), .stall_count(b_stall));

   typedef struct {
      logic [5:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [17:0] imm;
      logic [31:0] pc;
      logic [3:0]  e_rt;
      logic [31:0] e_imm_s;
      logic [31:0] e_imm_z;
      logic [8:0]  e_flags;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [3:0] rdv, input logic [3:0] rsv,
                        input logic [17:0] imm, input logic [31:0] pcv, input logic v);
      instruction = {op, rdv, rsv, imm};
      pc          = pcv;
      in_valid    = v;
      #1;
   endtask

   initial begin
      logic [31:0] held_pc;
      logic [5:0]  held_op;

      // flags: alu not cmp jmp ld str call ret src2
      tbl[0] = '{6'b000010, 4'h1, 4'h2, 18'h0C000, 32'h100, 4'h3, 32'h0000C000, 32'h0000C000, 9'b100000000};
      tbl[1] = '{6'b000011, 4'h4, 4'h5, 18'h3FFFF, 32'h104, 4'hF, 32'hFFFFFFFF, 32'h0003FFFF, 9'b100000001};
      tbl[2] = '{6'b000101, 4'h7, 4'h8, 18'h1FFFF, 32'h108, 4'h7, 32'h0001FFFF, 32'h0001FFFF, 9'b100000001};
      tbl[3] = '{6'b001110, 4'h9, 4'hA, 18'h00000, 32'h10C, 4'h0, 32'h00000000, 32'h00000000, 9'b110000000};
      tbl[4] = '{6'b100000, 4'h2, 4'h3, 18'h20000, 32'h110, 4'h8, 32'hFFFE0000, 32'h00020000, 9'b001000000};
      tbl[5] = '{6'b100011, 4'hE, 4'h0, 18'h00123, 32'h114, 4'h0, 32'h00000123, 32'h00000123, 9'b000100001};
      tbl[6] = '{6'b101000, 4'h0, 4'h0, 18'h00400, 32'h118, 4'h0, 32'h00000400, 32'h00000400, 9'b000000100};
      tbl[7] = '{6'b101010, 4'h0, 4'h0, 18'h00000, 32'h11C, 4'h0, 32'h00000000, 32'h00000000, 9'b000000010};
      tbl[8] = '{6'b100110, 4'h5, 4'h6, 18'h04000, 32'h120, 4'h1, 32'h00004000, 32'h00004000, 9'b000001000};
      tbl[9] = '{6'b100100, 4'h3, 4'h1, 18'h00000, 32'h124, 4'h0, 32'h00000000, 32'h00000000, 9'b000010000};

      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(6'b000010, 4'h1, 4'h2, 18'h0, 32'h40, 1'b1);
      step(); step();
      chk("rst_in_ready", {31'b0, a_in_ready}, 32'h0);
      chk("rst_hazard", {31'b0, a_hazard}, 32'h0);
      chk("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
      chk("rst_out_pc", a_out_pc, 32'h0);
      chk("rst_opcode", {26'b0, a_opcode}, 32'h0);
      chk("rst_imm", a_imm_ext, 32'h0);
      chk("rst_flags", {23'b0, a_flags}, 32'h0);
      chk("rst_stall", {16'b0, a_stall}, 32'h0);
      rst = 1'b0;
      drive(6'b0, 4'h0, 4'h0, 18'h0, 32'h0, 1'b0);

      // Streaming decode, one instruction per cycle
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].pc, 1'b1);
         chk($sformatf("v%0d_in_ready", i), {31'b0, a_in_ready}, 32'h1);
         step();
         chk($sformatf("v%0d_valid", i), {31'b0, a_out_valid}, 32'h1);
         chk($sformatf("v%0d_pc", i), a_out_pc, tbl[i].pc);
         chk($sformatf("v%0d_opcode", i), {26'b0, a_opcode}, {26'b0, tbl[i].op});
         chk($sformatf("v%0d_rd", i), {28'b0, a_rd}, {28'b0, tbl[i].rd});
         chk($sformatf("v%0d_cond", i), {28'b0, a_cond}, {28'b0, tbl[i].rd});
         chk($sformatf("v%0d_rs", i), {28'b0, a_rs}, {28'b0, tbl[i].rs});
         chk($sformatf("v%0d_rt", i), {28'b0, a_rt}, {28'b0, tbl[i].e_rt});
         chk($sformatf("v%0d_md", i), {10'b0, a_md}, {10'b0, tbl[i].rs, tbl[i].imm});
         chk($sformatf("v%0d_imm_s", i), a_imm_ext, tbl[i].e_imm_s);
         chk($sformatf("v%0d_imm_z", i), b_imm_ext, tbl[i].e_imm_z);
         chk($sformatf("v%0d_flags", i), {23'b0, a_flags}, {23'b0, tbl[i].e_flags});
      end
      drive(6'b0, 4'h0, 4'h0, 18'h0, 32'h0, 1'b0);
      step();
      chk("drain_valid", {31'b0, a_out_valid}, 32'h0);

      // LD r3 then independent ADD (rs=4, rt=5): no bubble
      drive(6'b100100, 4'h3, 4'h1, 18'h0, 32'h200, 1'b1); step();
      drive(6'b000010, 4'h6, 4'h4, 18'h14000, 32'h204, 1'b1);
      chk("nohz1_hazard", {31'b0, a_hazard}, 32'h0);
      chk("nohz1_in_ready", {31'b0, a_in_ready}, 32'h1);
      step();
      chk("nohz1_pc", a_out_pc, 32'h204);
      // LD r3 then ADDI rs=4 with rt field = 3: immediate form ignores rt
      drive(6'b100100, 4'h3, 4'h1, 18'h0, 32'h208, 1'b1); step();
      drive(6'b000011, 4'h6, 4'h4, 18'h0C000, 32'h20C, 1'b1);
      chk("nohz2_hazard", {31'b0, a_hazard}, 32'h0);
      step();
      chk("nohz2_pc", a_out_pc, 32'h20C);
      chk("nohz_stall", {16'b0, a_stall}, 32'h0);

      // LD r3 then ADD rs=3, rt=2: one bubble
      drive(6'b100100, 4'h3, 4'h1, 18'h0, 32'h300, 1'b1); step();
      drive(6'b000010, 4'h6, 4'h3, 18'h08000, 32'h304, 1'b1);
      chk("hz_hazard", {31'b0, a_hazard}, 32'h1);
      chk("hz_in_ready", {31'b0, a_in_ready}, 32'h0);
      chk("hzB_hazard", {31'b0, b_hazard}, 32'h0);
      step();
      chk("hz_bubble", {31'b0, a_out_valid}, 32'h0);
      chk("hz_stall1", {16'b0, a_stall}, 32'h1);
      chk("hz_clear", {31'b0, a_hazard}, 32'h0);
      step();
      chk("hz_add_valid", {31'b0, a_out_valid}, 32'h1);
      chk("hz_add_pc", a_out_pc, 32'h304);
      chk("hz_stall_hold", {16'b0, a_stall}, 32'h1);

      // LD r3 then STR with data register r3
      drive(6'b100100, 4'h3, 4'h1, 18'h0, 32'h400, 1'b1); step();
      drive(6'b100110, 4'h3, 4'h9, 18'h0, 32'h404, 1'b1);
      chk("str_hazard", {31'b0, a_hazard}, 32'h1);
      chk("strB_hazard", {31'b0, b_hazard}, 32'h0);
      chk("strB_in_ready", {31'b0, b_in_ready}, 32'h1);
      step();
      chk("str_bubble", {31'b0, a_out_valid}, 32'h0);
      chk("strB_valid", {31'b0, b_out_valid}, 32'h1);
      chk("strB_pc", b_out_pc, 32'h404);
      step();
      chk("str_valid", {31'b0, a_out_valid}, 32'h1);
      chk("str_pc", a_out_pc, 32'h404);
      chk("str_stall", {16'b0, a_stall}, 32'h2);
      chk("strB_stall", {16'b0, b_stall}, 32'h0);

      // Backpressure for 5 cycles, then flush with a new word presented
      drive(6'b000010, 4'h1, 4'h2, 18'h0, 32'h500, 1'b1); step();
      held_pc = 32'h500;
      held_op = 6'b000010;
      out_ready = 1'b0;
      drive(6'b000101, 4'h7, 4'h7, 18'h0, 32'h504, 1'b1);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_in_ready", c), {31'b0, a_in_ready}, 32'h0);
         step();
         chk($sformatf("bp%0d_valid", c), {31'b0, a_out_valid}, 32'h1);
         chk($sformatf("bp%0d_pc", c), a_out_pc, held_pc);
         chk($sformatf("bp%0d_op", c), {26'b0, a_opcode}, {26'b0, held_op});
      end
      flush = 1'b1;
      drive(6'b000110, 4'h8, 4'h8, 18'h0, 32'h508, 1'b1);
      chk("fl_in_ready", {31'b0, a_in_ready}, 32'h0);
      step();
      chk("fl_valid", {31'b0, a_out_valid}, 32'h0);
      chk("fl_pc_not_captured", a_out_pc, held_pc);
      flush = 1'b0; out_ready = 1'b1;
      drive(6'b0, 4'h0, 4'h0, 18'h0, 32'h0, 1'b0);
      step();
      chk("fl_still_empty", {31'b0, a_out_valid}, 32'h0);

      // Saturate stall_count: held LD stalled with a dependent ADD presented
      drive(6'b100100, 4'h3, 4'h1, 18'h0, 32'h600, 1'b1); step();
      out_ready = 1'b0;
      drive(6'b000010, 4'h6, 4'h3, 18'h08000, 32'h604, 1'b1);
      for (int c = 0; c < 65539; c++) step();
      chk("sat_stall", {16'b0, a_stall}, 32'h0000FFFF);
      chk("sat_hazard", {31'b0, a_hazard}, 32'h1);
      chk("sat_held_pc", a_out_pc, 32'h600);

      // Reset with a held instruction
      rst = 1'b1; #1;
      chk("mrst_in_ready", {31'b0, a_in_ready}, 32'h0);
      chk("mrst_hazard", {31'b0, a_hazard}, 32'h0);
      step();
      chk("mrst_valid", {31'b0, a_out_valid}, 32'h0);
      chk("mrst_stall", {16'b0, a_stall}, 32'h0);
      chk("mrst_pc", a_out_pc, 32'h0);
      chk("mrst_flags", {23'b0, a_flags}, 32'h0);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
